dtw_stream_feeder: RTL and testbench
====================================

Name: dtw_stream_feeder

Overview:
- Upstream controller for the systolic DTW core. Accepts a query-squiggle stream and a reference stream, each over a valid/ready handshake, and presents them to the core one pair per advance cycle.
- Drives the core's `running` advance/stall input and its synchronous clear. Feeds flush words until the core's `done` rises, then returns `minval`/`position` over a valid/ready result handshake.

Parameters:
- WIDTH, 16, sample/word/score width (matches core `width`)
- SQG_SIZE, 250, query length = core PE count
- POST_CYC, 2, advance cycles after `done` before result capture (covers lastrow + min-update registers)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; ignored unless in IDLE
- ref_len  in  32  reference word count, latched on accepted start
- q_valid  in  1  query sample valid
- q_data  in  WIDTH  query sample
- q_ready  out  1  query sample accepted when q_valid&q_ready
- r_valid  in  1  reference word valid
- r_data  in  WIDTH  reference word
- r_ready  out  1  reference word accepted when r_valid&r_ready
- core_rst  out  1  synchronous active-high clear to core
- core_running  out  1  core advance enable
- core_squiggle  out  WIDTH  to core Input_squiggle
- core_rword  out  WIDTH  to core Rword
- core_done  in  1  core done
- core_minval  in  WIDTH  core minimum score
- core_position  in  32  core minimum position
- res_valid  out  1  result valid
- res_minval  out  WIDTH  captured minimum
- res_position  out  32  captured position
- res_ready  in  1  result consumer ready
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE, counters 0, ref_len_q 0. core_rst=1, core_running=0, q_ready=r_ready=0, res_valid=0, res_minval=0, res_position=0, core_squiggle=core_rword=0.
- States and transitions:
  - IDLE: start → CLEAR, latching ref_len. Assert core_rst while in IDLE.
  - CLEAR: one cycle, core_rst=1 → RUN.
  - RUN, advance condition: adv = (q_cnt<SQG_SIZE ? q_valid : 1) & (r_cnt<ref_len_q ? r_valid : 1).
  - RUN, on adv: core_running=1; q_ready=adv&(q_cnt<SQG_SIZE); r_ready=adv&(r_cnt<ref_len_q); both counters increment when their stream handshakes.
  - RUN, stall: no adv → core_running=0; the core freezes entirely. This stall is the core's only flow control.
  - RUN, data outputs: core_squiggle = q_data while q_cnt<SQG_SIZE, else 0. core_rword = r_data while r_cnt<ref_len_q, else 0 (flush word). Both are combinational pass-through, same cycle as the handshake.
  - RUN → DRAIN when core_done is sampled high. post_cnt clears.
  - DRAIN: core_running=1 every cycle, flush words. After POST_CYC cycles → RESULT, capturing core_minval/core_position into res_*.
  - RESULT: res_valid=1 and held stable until res_ready → IDLE, clearing res_valid.
- Latency, unstalled job: ref_len+SQG_SIZE+POST_CYC+~3 cycles from start to res_valid.
- ref_len=0: RUN feeds query plus flushes. The core's `done` is already high, so RUN → DRAIN after the first RUN cycle; the result is whatever the core holds (Minval all-ones).
- ref_len < SQG_SIZE is legal: the reference side flushes while the query is still being loaded.
- Counters are 32-bit and saturate rather than wrap.
- start while not IDLE is ignored. res_ready while not RESULT is ignored.
- rst_n asserted mid-job: immediate return to IDLE with core_rst high. Partially consumed streams are the upstream's responsibility.

Optional Feature:
- DTW_FEEDER_PERF_EN defined:
  - adds outputs perf_stall (32) and perf_total (32).
  - Cycles in RUN with adv=0 and cycles from CLEAR to RESULT are counted, saturating.
  - Both counters clear on accepted start and are valid from res_valid.
- DTW_FEEDER_PERF_EN undefined: those ports and counters do not exist.

Decomposition:
- Package dtw_pkg:
  - state enum (IDLE, CLEAR, RUN, DRAIN, RESULT)
  - DTW_WIDTH=16, DTW_SQG_SIZE=250, DTW_POST_CYC=2
  - sample typedef of WIDTH bits
- Sub-module dtw_sat_counter: 32-bit saturating counter with clear/enable, instantiated for q_cnt, r_cnt, post_cnt and the perf counters. Everything else stays flat.

Test Plan:
- Reset/idle: rst_n low mid-RUN → next edge state IDLE, core_rst=1, core_running=0, res_valid=0. Check with SQG_SIZE=4, ref_len=8.
- Nominal: SQG_SIZE=4, ref_len=8, both streams always valid.
  - q_ready high exactly 4 cycles and r_ready exactly 8 cycles, core_running continuous.
  - Flush rword=0 after 8 words; res_valid 2 cycles after DRAIN entry.
  - Against a core model, res_minval/res_position match a golden DTW.
- Stalls: drop r_valid for 3 cycles at r_cnt=2 and q_valid for 1 cycle at q_cnt=1 → core_running low on exactly those 4 cycles. Result is identical to the nominal run; perf_stall=4 with the macro defined.
- Backpressure: hold res_ready low 10 cycles → res_valid, res_minval and res_position stable. A start pulse during that window is ignored; a start after the IDLE return launches a new job.
- Edge lengths: ref_len=0 → DRAIN reached within 2 RUN cycles, res_minval=16'hFFFF. ref_len=1 with SQG_SIZE=4 → r_ready exactly 1 cycle, then 3 or more flush cycles.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared widths, defaults and the FSM state type for the DTW stream feeder.
package dtw_pkg;

  localparam int DTW_WIDTH    = 16;
  localparam int DTW_SQG_SIZE = 250;
  localparam int DTW_POST_CYC = 2;

  typedef logic [DTW_WIDTH-1:0] dtw_sample_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } dtw_state_t;

endpackage

// File: rtl/dtw_stream_feeder_if.sv
// Stream, core-side and result signals of the DTW feeder; master = feeder, slave = environment.
// DTW_FEEDER_PERF_EN adds the perf_stall/perf_total counters.
interface dtw_stream_feeder_if
  import dtw_pkg::*;
#(
  parameter int WIDTH = DTW_WIDTH
);

  logic             start;
  logic [31:0]      ref_len;
  logic             q_valid;
  logic [WIDTH-1:0] q_data;
  logic             q_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_ready;
  logic             core_rst;
  logic             core_running;
  logic [WIDTH-1:0] core_squiggle;
  logic [WIDTH-1:0] core_rword;
  logic             core_done;
  logic [WIDTH-1:0] core_minval;
  logic [31:0]      core_position;
  logic             res_valid;
  logic [WIDTH-1:0] res_minval;
  logic [31:0]      res_position;
  logic             res_ready;
  logic             busy;
`ifdef DTW_FEEDER_PERF_EN
  logic [31:0]      perf_stall;
  logic [31:0]      perf_total;
`endif

  modport master (
    input  start, ref_len, q_valid, q_data, r_valid, r_data,
           core_done, core_minval, core_position, res_ready,
    output q_ready, r_ready, core_rst, core_running, core_squiggle, core_rword,
           res_valid, res_minval, res_position, busy
`ifdef DTW_FEEDER_PERF_EN
    , output perf_stall, perf_total
`endif
  );

  modport slave (
    output start, ref_len, q_valid, q_data, r_valid, r_data,
           core_done, core_minval, core_position, res_ready,
    input  q_ready, r_ready, core_rst, core_running, core_squiggle, core_rword,
           res_valid, res_minval, res_position, busy
`ifdef DTW_FEEDER_PERF_EN
    , input perf_stall, perf_total
`endif
  );

endinterface

// File: rtl/dtw_sat_counter.sv
// 32-bit up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module dtw_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [31:0] o_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en && (o_cnt != 32'hFFFF_FFFF)) begin
      o_cnt <= o_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/dtw_stream_feeder.sv
// Feeds query/reference streams into the systolic DTW core, drains it and returns the result.
// Optional DTW_FEEDER_PERF_EN adds stall/total cycle counters.
module dtw_stream_feeder
  import dtw_pkg::*;
#(
  parameter int WIDTH    = DTW_WIDTH,
  parameter int SQG_SIZE = DTW_SQG_SIZE,
  parameter int POST_CYC = DTW_POST_CYC  // must be >= 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dtw_stream_feeder_if.master bus
);

  // state  | meaning
  // IDLE   | core held in clear, waiting for start
  // CLEAR  | one clear cycle after start
  // RUN    | one pair per advance; stall whenever a live stream is not valid
  // DRAIN  | POST_CYC flush advances after core done
  // RESULT | result held until res_ready
  dtw_state_t       r_state, w_state_nxt;
  logic [31:0]      r_ref_len;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_minval;
  logic [31:0]      r_res_position;

  logic [31:0]      w_q_cnt, w_r_cnt, w_post_cnt;
  logic             w_start_acc, w_in_run, w_in_drain;
  logic             w_q_more, w_r_more, w_adv, w_cap;
  logic             w_core_rst, w_core_running, w_q_ready, w_r_ready;
  logic [WIDTH-1:0] w_squiggle, w_rword;

  assign w_start_acc = (r_state == ST_IDLE) && bus.start;
  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_drain  = (r_state == ST_DRAIN);
  assign w_q_more    = (w_q_cnt < 32'(SQG_SIZE));
  assign w_r_more    = (w_r_cnt < r_ref_len);
  assign w_adv       = (w_q_more ? bus.q_valid : 1'b1) & (w_r_more ? bus.r_valid : 1'b1);

  always_comb begin
    w_state_nxt    = r_state;
    w_core_rst     = 1'b0;
    w_core_running = 1'b0;
    w_q_ready      = 1'b0;
    w_r_ready      = 1'b0;
    w_squiggle     = '0;
    w_rword        = '0;
    w_cap          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_core_rst = 1'b1;
        if (bus.start) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_core_rst  = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_core_running = w_adv;
        w_q_ready      = w_adv & w_q_more;
        w_r_ready      = w_adv & w_r_more;
        w_squiggle     = w_q_more ? bus.q_data : '0;
        w_rword        = w_r_more ? bus.r_data : '0;
        if (bus.core_done) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_core_running = 1'b1;
        if (w_post_cnt >= 32'(POST_CYC - 1)) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ref_len      <= '0;
      r_res_valid    <= 1'b0;
      r_res_minval   <= '0;
      r_res_position <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) r_ref_len <= bus.ref_len;
      // capture on the last drain edge; the core advances on that same edge
      if (w_cap) begin
        r_res_valid    <= 1'b1;
        r_res_minval   <= bus.core_minval;
        r_res_position <= bus.core_position;
      end else if ((r_state == ST_RESULT) && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  dtw_sat_counter u_q_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_en(w_q_ready), .o_cnt(w_q_cnt)
  );
  dtw_sat_counter u_r_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_en(w_r_ready), .o_cnt(w_r_cnt)
  );
  dtw_sat_counter u_post_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_in_run), .i_en(w_in_drain), .o_cnt(w_post_cnt)
  );

`ifdef DTW_FEEDER_PERF_EN
  logic [31:0] w_perf_stall, w_perf_total;
  logic        w_perf_active;

  assign w_perf_active = (r_state == ST_CLEAR) || w_in_run || w_in_drain;

  dtw_sat_counter u_perf_stall (
    .clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_en(w_in_run && !w_adv),
    .o_cnt(w_perf_stall)
  );
  dtw_sat_counter u_perf_total (
    .clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_en(w_perf_active),
    .o_cnt(w_perf_total)
  );

  assign bus.perf_stall = w_perf_stall;
  assign bus.perf_total = w_perf_total;
`endif

  assign bus.q_ready       = w_q_ready;
  assign bus.r_ready       = w_r_ready;
  assign bus.core_rst      = w_core_rst;
  assign bus.core_running  = w_core_running;
  assign bus.core_squiggle = w_squiggle;
  assign bus.core_rword    = w_rword;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_minval    = r_res_minval;
  assign bus.res_position  = r_res_position;
  assign bus.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dtw_stream_feeder.sv
// Bench for dtw_stream_feeder: random streams, a behavioural DTW core stub and a golden DTW.
module tb_dtw_stream_feeder;
  import dtw_pkg::*;

  localparam int W = 16;
  localparam int S = 4;
  localparam int P = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtw_stream_feeder_if #(.WIDTH(W)) bus ();
  dtw_stream_feeder #(.WIDTH(W), .SQG_SIZE(S), .POST_CYC(P)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // subsequence DTW: min over end positions j of the full-query alignment cost
  function automatic void dtw_ref(input int qa[8], input int ra[64], input int n, input int m,
                                  output logic [15:0] mn, output logic [31:0] pos);
    int d[8][64];
    int c, a, best;
    mn  = 16'hFFFF;
    pos = '0;
    if (m == 0) return;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < m; j++) begin
        c = (qa[i] > ra[j]) ? qa[i] - ra[j] : ra[j] - qa[i];
        if (i == 0) d[i][j] = c;
        else if (j == 0) d[i][j] = d[i-1][0] + c;
        else begin
          a = d[i-1][j-1];
          if (d[i-1][j] < a) a = d[i-1][j];
          if (d[i][j-1] < a) a = d[i][j-1];
          d[i][j] = a + c;
        end
      end
    end
    best = d[n-1][0];
    for (int j = 1; j < m; j++) begin
      if (d[n-1][j] < best) begin
        best = d[n-1][j];
        pos  = 32'(j);
      end
    end
    mn = 16'(best);
  endfunction

  // core stub: collects what it is fed, raises done after len+S advances
  int          job_len = 1;
  int          n_adv   = 0;
  dtw_sample_t cq[$];
  dtw_sample_t cr[$];
  logic [15:0] stub_min = 16'hFFFF;
  logic [31:0] stub_pos = '0;

  assign bus.core_done     = (job_len == 0) || (n_adv >= job_len + S);
  assign bus.core_minval   = stub_min;
  assign bus.core_position = stub_pos;

  function automatic logic [47:0] stub_eval();
    int qa[8];
    int ra[64];
    logic [15:0] mn;
    logic [31:0] ps;
    for (int i = 0; i < 8; i++)  qa[i] = (i < cq.size()) ? int'(cq[i]) : 0;
    for (int i = 0; i < 64; i++) ra[i] = (i < cr.size()) ? int'(cr[i]) : 0;
    dtw_ref(qa, ra, S, job_len, mn, ps);
    return {mn, ps};
  endfunction

  always @(posedge clk) begin
    if (bus.core_rst) begin
      cq.delete();
      cr.delete();
      n_adv    <= 0;
      stub_min <= 16'hFFFF;
      stub_pos <= '0;
    end else if (bus.core_running) begin
      if (cq.size() < S) cq.push_back(bus.core_squiggle);
      if (cr.size() < job_len) cr.push_back(bus.core_rword);
      n_adv <= n_adv + 1;
      if (job_len > 0 && n_adv + 1 == job_len + S) {stub_min, stub_pos} <= stub_eval();
    end
  end

  int qs[8];
  int rs[64];
  int o_qrdy, o_rrdy, o_stall, o_run, o_flush, o_lat, o_d2r, o_derr, o_unstable, o_after, o_timeout;
  logic [15:0] o_min, e_min, nom_min;
  logic [31:0] o_pos, e_pos, nom_pos, o_pstall, o_ptotal;

  task automatic run_job(input int len, input bit new_data, input int q_at, input int q_n,
                         input int r_at, input int r_n, input int hold, input bit poke_start);
    int qp, rp, q_left, r_left, cyc, done_cyc;
    bit got;
    job_len = len;
    if (new_data) begin
      for (int i = 0; i < S; i++)   qs[i] = int'($urandom_range(1, 15));
      for (int i = 0; i < len; i++) rs[i] = int'($urandom_range(1, 15));
    end
    dtw_ref(qs, rs, S, len, e_min, e_pos);
    {o_qrdy, o_rrdy, o_stall, o_run, o_flush, o_lat} = '0;
    {o_d2r, o_derr, o_unstable, o_after, o_timeout} = '0;
    o_pstall = '0; o_ptotal = '0;
    qp = 0; rp = 0; q_left = q_n; r_left = r_n; done_cyc = -1; got = 1'b0;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.ref_len = 32'(len); bus.res_ready = 1'b0;
    @(posedge clk); #2;
    bus.start = 1'b0;
    for (cyc = 0; cyc < 300 && !got; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #2; end
      bus.q_valid = !(qp == q_at && q_left > 0);
      bus.q_data  = (qp < S) ? 16'(qs[qp]) : 16'($urandom_range(1, 15));
      bus.r_valid = !(rp == r_at && r_left > 0);
      bus.r_data  = (rp < len) ? 16'(rs[rp]) : 16'($urandom_range(1, 15));
      #1;
      if (bus.res_valid === 1'b1) begin
        got   = 1'b1;
        o_lat = cyc;
        o_d2r = cyc - done_cyc;
        o_min = bus.res_minval;
        o_pos = bus.res_position;
`ifdef DTW_FEEDER_PERF_EN
        o_pstall = bus.perf_stall;
        o_ptotal = bus.perf_total;
`endif
      end else if (bus.busy === 1'b1 && bus.core_rst === 1'b0) begin
        if (bus.core_running === 1'b1) begin
          o_run++;
          if (bus.q_ready === 1'b1) begin
            o_qrdy++;
            if (qp >= S || bus.core_squiggle !== 16'(qs[qp])) o_derr++;
          end else if (bus.core_squiggle !== '0) o_derr++;
          if (bus.r_ready === 1'b1) begin
            o_rrdy++;
            if (rp >= len || bus.core_rword !== 16'(rs[rp])) o_derr++;
          end else begin
            o_flush++;
            if (bus.core_rword !== '0) o_derr++;
          end
        end else begin
          o_stall++;
          if (bus.q_ready !== 1'b0 || bus.r_ready !== 1'b0) o_derr++;
        end
        if (!bus.q_valid) q_left--;
        if (!bus.r_valid) r_left--;
        if (bus.core_done && done_cyc < 0) done_cyc = cyc;
        if (bus.q_valid && bus.q_ready === 1'b1) qp++;
        if (bus.r_valid && bus.r_ready === 1'b1) rp++;
      end
    end
    if (!got) o_timeout = 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      bus.start = poke_start && (h == 3);
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_minval !== o_min || bus.res_position !== o_pos ||
          bus.busy !== 1'b1) o_unstable++;
    end
    @(posedge clk); #2;
    bus.start = 1'b0; bus.res_ready = 1'b1;
    @(posedge clk); #2;
    bus.res_ready = 1'b0;
    #1;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) o_after++;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.res_ready = 1'b0; bus.ref_len = '0;
    bus.q_valid = 1'b1; bus.q_data = 16'h1234; bus.r_valid = 1'b1; bus.r_data = 16'h5678;
    rst_n = 1'b0;
    #12;
    total++; if ({bus.core_rst, bus.core_running, bus.q_ready, bus.r_ready, bus.res_valid, bus.busy} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b expected 100000", {bus.core_rst, bus.core_running, bus.q_ready, bus.r_ready, bus.res_valid, bus.busy}); end
    total++; if ({bus.res_minval, bus.res_position, bus.core_squiggle, bus.core_rword} !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h %h expected zeros", bus.res_minval, bus.res_position, bus.core_squiggle, bus.core_rword); end
    @(negedge clk) rst_n = 1'b1;
    job_len = 8;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.ref_len = 32'd8;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    total++; if (bus.core_running !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL midrun_running: got run=%b busy=%b expected 1 1", bus.core_running, bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.busy, bus.core_rst, bus.core_running, bus.res_valid, bus.q_ready} !== 5'b01000) begin
      bad++; $display("FAIL midrun_async_rst: got %b expected 01000", {bus.busy, bus.core_rst, bus.core_running, bus.res_valid, bus.q_ready}); end
    @(posedge clk); #1;
    total++; if ({bus.busy, bus.core_rst, bus.core_running, bus.res_valid, bus.r_ready} !== 5'b01000) begin
      bad++; $display("FAIL midrun_after_edge: got %b expected 01000", {bus.busy, bus.core_rst, bus.core_running, bus.res_valid, bus.r_ready}); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    run_job(8, 1'b1, -1, 0, -1, 0, 0, 1'b0);
    nom_min = o_min; nom_pos = o_pos;
    total++; if (o_timeout !== 0) begin bad++; $display("FAIL nom_timeout: got %0d expected 0", o_timeout); end
    total++; if (o_qrdy !== S) begin bad++; $display("FAIL nom_q_ready: got %0d expected %0d", o_qrdy, S); end
    total++; if (o_rrdy !== 8) begin bad++; $display("FAIL nom_r_ready: got %0d expected 8", o_rrdy); end
    total++; if (o_stall !== 0 || o_run !== 8 + S + 1 + P) begin
      bad++; $display("FAIL nom_running: got stall=%0d run=%0d expected 0 %0d", o_stall, o_run, 8 + S + 1 + P); end
    total++; if (o_flush !== S + 1 + P) begin bad++; $display("FAIL nom_flush: got %0d expected %0d", o_flush, S + 1 + P); end
    total++; if (o_derr !== 0) begin bad++; $display("FAIL nom_data: got %0d errors expected 0", o_derr); end
    total++; if (o_d2r !== P + 1) begin bad++; $display("FAIL nom_done_to_res: got %0d expected %0d", o_d2r, P + 1); end
    total++; if (o_lat !== 8 + S + P + 2) begin bad++; $display("FAIL nom_latency: got %0d expected %0d", o_lat, 8 + S + P + 2); end
    total++; if (o_min !== e_min || o_pos !== e_pos) begin
      bad++; $display("FAIL nom_result: got %0d@%0d expected %0d@%0d", o_min, o_pos, e_min, e_pos); end
    total++; if (o_after !== 0) begin bad++; $display("FAIL nom_release: got %0d expected 0", o_after); end
  endtask

  task automatic test_stalls();
    run_job(8, 1'b0, 1, 1, 2, 3, 0, 1'b0);
    total++; if (o_stall !== 4 || o_run !== 8 + S + 1 + P) begin
      bad++; $display("FAIL stall_cycles: got stall=%0d run=%0d expected 4 %0d", o_stall, o_run, 8 + S + 1 + P); end
    total++; if (o_qrdy !== S || o_rrdy !== 8 || o_derr !== 0) begin
      bad++; $display("FAIL stall_stream: got q=%0d r=%0d err=%0d expected %0d 8 0", o_qrdy, o_rrdy, o_derr, S); end
    total++; if (o_lat !== 8 + S + P + 2 + 4) begin bad++; $display("FAIL stall_latency: got %0d expected %0d", o_lat, 8 + S + P + 6); end
    total++; if (o_min !== nom_min || o_pos !== nom_pos || o_min !== e_min) begin
      bad++; $display("FAIL stall_result: got %0d@%0d expected %0d@%0d", o_min, o_pos, e_min, e_pos); end
`ifdef DTW_FEEDER_PERF_EN
    total++; if (o_pstall !== 32'd4) begin bad++; $display("FAIL perf_stall: got %0d expected 4", o_pstall); end
    total++; if (o_ptotal !== 32'(8 + S + P + 6)) begin bad++; $display("FAIL perf_total: got %0d expected %0d", o_ptotal, 8 + S + P + 6); end
`endif
  endtask

  task automatic test_backpressure();
    run_job(5, 1'b1, -1, 0, -1, 0, 10, 1'b1);
    total++; if (o_unstable !== 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", o_unstable); end
    total++; if (o_after !== 0) begin bad++; $display("FAIL bp_release: got %0d expected 0", o_after); end
    total++; if (o_min !== e_min || o_pos !== e_pos) begin
      bad++; $display("FAIL bp_result: got %0d@%0d expected %0d@%0d", o_min, o_pos, e_min, e_pos); end
    run_job(3, 1'b1, -1, 0, -1, 0, 0, 1'b0);
    total++; if (o_timeout !== 0 || o_rrdy !== 3 || o_qrdy !== S) begin
      bad++; $display("FAIL bp_restart: got to=%0d r=%0d q=%0d expected 0 3 %0d", o_timeout, o_rrdy, o_qrdy, S); end
    total++; if (o_min !== e_min || o_pos !== e_pos) begin
      bad++; $display("FAIL bp_restart_result: got %0d@%0d expected %0d@%0d", o_min, o_pos, e_min, e_pos); end
  endtask

  task automatic test_edge_lengths();
    run_job(0, 1'b1, -1, 0, -1, 0, 0, 1'b0);
    total++; if (o_timeout !== 0 || o_run > 2 + P || o_d2r !== P + 1) begin
      bad++; $display("FAIL len0_drain: got to=%0d run=%0d d2r=%0d expected 0 <=%0d %0d", o_timeout, o_run, o_d2r, 2 + P, P + 1); end
    total++; if (o_min !== 16'hFFFF || o_rrdy !== 0) begin
      bad++; $display("FAIL len0_result: got min=%h r=%0d expected ffff 0", o_min, o_rrdy); end
    run_job(1, 1'b1, -1, 0, -1, 0, 0, 1'b0);
    total++; if (o_rrdy !== 1 || o_flush < 3 || o_derr !== 0) begin
      bad++; $display("FAIL len1_flush: got r=%0d flush=%0d err=%0d expected 1 >=3 0", o_rrdy, o_flush, o_derr); end
    total++; if (o_min !== e_min || o_pos !== e_pos) begin
      bad++; $display("FAIL len1_result: got %0d@%0d expected %0d@%0d", o_min, o_pos, e_min, e_pos); end
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 4; k++) begin
      len = int'($urandom_range(2, 12));
      run_job(len, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, len - 1)), int'($urandom_range(0, 3)), 0, 1'b0);
      total++; if (o_timeout !== 0 || o_qrdy !== S || o_rrdy !== len || o_derr !== 0) begin
        bad++; $display("FAIL rand_stream[%0d]: got to=%0d q=%0d r=%0d err=%0d expected 0 %0d %0d 0", k, o_timeout, o_qrdy, o_rrdy, o_derr, S, len); end
      total++; if (o_lat !== len + S + P + 2 + o_stall) begin
        bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, o_lat, len + S + P + 2 + o_stall); end
      total++; if (o_min !== e_min || o_pos !== e_pos) begin
        bad++; $display("FAIL rand_result[%0d]: got %0d@%0d expected %0d@%0d", k, o_min, o_pos, e_min, e_pos); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stalls();
    test_backpressure();
    test_edge_lengths();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
